// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory and loads the IF/ID register, handling stalls (replay) and redirects (flush).
module fetch_stage #(
  parameter int unsigned            PC_W      = 32,
  parameter int unsigned            INSTR_W   = 32,
  parameter logic [PC_W-1:0]        RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]     NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic [PC_W-1:0]    id_pc_plus4
);

  localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic               resp_valid_q, resp_valid_d;
  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [PC_W-1:0]    id_pc_q, id_pc_d;
  logic [PC_W-1:0]    id_pc_plus4_q, id_pc_plus4_d;
  logic [PC_W-1:0]    aligned_target;

  assign aligned_target = {redirect_pc[PC_W-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      fetch_pc_q    <= '0;
      resp_valid_q  <= 1'b0;
      id_valid_q    <= 1'b0;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_valid_q  <= resp_valid_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
    end
  end

  always_comb begin
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    resp_valid_d  = resp_valid_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    if (redirect) begin
      // Wrong-path response on imem_rdata is dropped; id_pc is left as-is since id_valid=0.
      pc_d         = aligned_target + PC_INC;
      fetch_pc_d   = aligned_target;
      resp_valid_d = 1'b1;
      id_valid_d   = 1'b0;
      id_instr_d   = NOP_INSTR;
    end else if (!stall) begin
      pc_d          = pc_q + PC_INC;
      fetch_pc_d    = pc_q;
      resp_valid_d  = 1'b1;
      id_valid_d    = resp_valid_q;
      id_instr_d    = resp_valid_q ? imem_rdata : NOP_INSTR;
      id_pc_d       = fetch_pc_q;
      id_pc_plus4_d = fetch_pc_q + PC_INC;
    end
  end

  // Stall replays the in-flight address so the held instruction is re-read, not lost.
  always_comb begin
    imem_en   = 1'b1;
    imem_addr = pc_q;
    if (redirect) begin
      imem_addr = aligned_target;
    end else if (stall) begin
      imem_en   = resp_valid_q;
      imem_addr = fetch_pc_q;
    end
  end

  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory word at address A holds A+0x100.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  int errors = 0;
  int checks = 0;

  fetch_stage #(
    .PC_W(32), .INSTR_W(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_rdata <= imem_addr + 32'h100;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    rst_n = 1'b0;
    #2;
    checks++;
    if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL reset_id: valid=%b instr=%h pc=%h pc4=%h, want 0/0/0/0", id_valid, id_instr, id_pc, id_pc_plus4);
    end
    checks++;
    if (imem_en !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_req: en=%b addr=%h, want 1/0", imem_en, imem_addr);
    end
  endtask

  // Free-run to id_pc=8, then stall for three cycles.
  task automatic test_freerun_stall();
    apply_reset();
    tick();
    checks++;
    if (id_valid !== 1'b0) begin errors++; $display("FAIL first_latency: id_valid=%b want 0", id_valid); end
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4*k) || id_instr !== 32'(4*k + 32'h100) || id_pc_plus4 !== 32'(4*k + 4)) begin
        errors++;
        $display("FAIL freerun_%0d: valid=%b pc=%h instr=%h pc4=%h want 1/%h/%h/%h", k, id_valid, id_pc, id_instr, id_pc_plus4, 4*k, 4*k + 32'h100, 4*k + 4);
      end
    end
    stall = 1'b1;
    #1;
    checks++;
    if (imem_en !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL stall_addr: en=%b addr=%h want 1/0000000c", imem_en, imem_addr); end
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== 32'h108 || imem_addr !== 32'hC) begin
        errors++;
        $display("FAIL stall_hold_%0d: valid=%b pc=%h instr=%h addr=%h want 1/8/108/c", k, id_valid, id_pc, id_instr, imem_addr);
      end
    end
    stall = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 32'h10) begin errors++; $display("FAIL unstall_addr: addr=%h want 00000010", imem_addr); end
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'hC || id_instr !== 32'h10C) begin errors++; $display("FAIL unstall_1: pc=%h instr=%h want c/10c", id_pc, id_instr); end
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h10 || id_instr !== 32'h110) begin errors++; $display("FAIL unstall_2: pc=%h instr=%h want 10/110", id_pc, id_instr); end
  endtask

  task automatic test_stall_after_reset();
    apply_reset();
    tick();
    stall = 1'b1;
    #1;
    checks++;
    if (imem_en !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL early_stall_req: en=%b addr=%h want 1/0", imem_en, imem_addr); end
    tick(); tick();
    checks++;
    if (id_valid !== 1'b0) begin errors++; $display("FAIL early_stall_hold: id_valid=%b want 0", id_valid); end
    stall = 1'b0;
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h100) begin errors++; $display("FAIL early_stall_release: valid=%b pc=%h instr=%h want 1/0/100", id_valid, id_pc, id_instr); end
  endtask

  task automatic test_redirect();
    apply_reset();
    tick(); tick(); tick();
    checks++;
    if (id_pc !== 32'h4) begin errors++; $display("FAIL redir_setup: id_pc=%h want 4", id_pc); end
    redirect = 1'b1; redirect_pc = 32'h40;
    #1;
    checks++;
    if (imem_addr !== 32'h40) begin errors++; $display("FAIL redir_addr: addr=%h want 40", imem_addr); end
    tick();
    redirect = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || id_instr !== 32'h0) begin errors++; $display("FAIL redir_flush: valid=%b instr=%h want 0/0", id_valid, id_instr); end
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== 32'h140 || id_pc_plus4 !== 32'h44) begin
      errors++; $display("FAIL redir_target: valid=%b pc=%h instr=%h pc4=%h want 1/40/140/44", id_valid, id_pc, id_instr, id_pc_plus4);
    end
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h44 || id_instr !== 32'h144) begin errors++; $display("FAIL redir_next: pc=%h instr=%h want 44/144", id_pc, id_instr); end
  endtask

  task automatic test_stall_and_redirect();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h23;
    #1;
    checks++;
    if (imem_en !== 1'b1 || imem_addr !== 32'h20) begin errors++; $display("FAIL sr_addr: en=%b addr=%h want 1/20", imem_en, imem_addr); end
    tick();
    stall = 1'b0; redirect = 1'b0;
    checks++;
    if (id_valid !== 1'b0) begin errors++; $display("FAIL sr_flush: id_valid=%b want 0", id_valid); end
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h20 || id_instr !== 32'h120) begin errors++; $display("FAIL sr_target: valid=%b pc=%h instr=%h want 1/20/120", id_valid, id_pc, id_instr); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: addr=%h want 0", imem_addr); end
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_instr !== 32'h0000_00FC || id_pc_plus4 !== 32'h0) begin
      errors++; $display("FAIL wrap_top: pc=%h instr=%h pc4=%h want fffffffc/000000fc/0", id_pc, id_instr, id_pc_plus4);
    end
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h100 || id_pc_plus4 !== 32'h4) begin
      errors++; $display("FAIL wrap_zero: pc=%h instr=%h pc4=%h want 0/100/4", id_pc, id_instr, id_pc_plus4);
    end
  endtask

  task automatic test_midstream_reset();
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0) begin errors++; $display("FAIL async_reset: valid=%b pc=%h instr=%h want 0/0/0", id_valid, id_pc, id_instr); end
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_addr !== 32'h0 || imem_en !== 1'b1) begin errors++; $display("FAIL restart_req: en=%b addr=%h want 1/0", imem_en, imem_addr); end
    tick();
    checks++;
    if (id_valid !== 1'b0) begin errors++; $display("FAIL restart_latency: id_valid=%b want 0", id_valid); end
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h100) begin errors++; $display("FAIL restart_first: valid=%b pc=%h instr=%h want 1/0/100", id_valid, id_pc, id_instr); end
  endtask

  initial begin
    test_reset();
    test_freerun_stall();
    test_stall_after_reset();
    test_redirect();
    test_stall_and_redirect();
    test_wrap();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
